// File: rtl/lsu_mem32_ctrl_if.sv
// lsu_mem32_ctrl_if: core request/response channel and 4-bank byte-lane memory port of the load/store unit
interface lsu_mem32_ctrl_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_raddress;
    logic [ADDR_W-1:0] mem_waddress;
    logic [31:0]       mem_datain;
    logic [3:0]        mem_wr;
    logic [31:0]       mem_dataout;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dataout,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_raddress, mem_waddress, mem_datain, mem_wr
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dataout,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_raddress, mem_waddress, mem_datain, mem_wr
    );
endinterface

// File: rtl/lsu_mem32_ctrl.sv
// lsu_mem32_ctrl: single-outstanding load/store initiator for a 4-bank byte-lane memory; LSU_MISALIGN_TRAP_EN selects trapping of misaligned accesses
module lsu_mem32_ctrl #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input logic Clk,
    input logic Reset,
    lsu_mem32_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STORE, LOAD_WAIT, RESP} state_t;
    state_t            state;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              uns_q;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] addr_al;
    logic [1:0]        off_in;
    logic [3:0]        wr_lanes;
    logic [31:0]       wdata_lanes;
    logic [31:0]       shifted;
    logic [31:0]       load_ext;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              mis;
`endif
    // request decode: aligned address, lane offset, store lane steering and load extraction
    always_comb begin
        addr_al     = {bus.req_addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
        mis         = (bus.req_size == 2'b01 && bus.req_addr[0]) || (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
        off_in      = bus.req_addr[1:0];
`else
        off_in      = bus.req_size[1] ? 2'b00 : bus.req_size[0] ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
`endif
        wr_lanes    = bus.req_size[1] ? 4'b1111 : bus.req_size[0] ? 4'b0011 << off_in : 4'b0001 << off_in;
        wdata_lanes = bus.req_size[1] ? bus.req_wdata : bus.req_size[0] ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
        shifted     = bus.mem_dataout >> {off_q, 3'b000};
        load_ext    = size_q[1] ? bus.mem_dataout
                    : size_q[0] ? {{16{~uns_q & shifted[15]}}, shifted[15:0]}
                    : {{24{~uns_q & shifted[7]}}, shifted[7:0]};
    end
    // the read address is presented in IDLE so the memory samples it on the accept edge, then held while waiting
    assign bus.req_ready    = state == IDLE && !Reset;
    assign bus.mem_raddress = state != IDLE ? raddr_q : Reset ? '0 : addr_al;
    // control FSM with registered response and memory-write outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= IDLE;
            size_q           <= '0;
            off_q            <= '0;
            uns_q            <= 1'b0;
            cnt              <= '0;
            raddr_q          <= '0;
            bus.resp_valid   <= 1'b0;
            bus.resp_rdata   <= '0;
            bus.resp_err     <= 1'b0;
            bus.mem_wr       <= '0;
            bus.mem_waddress <= '0;
            bus.mem_datain   <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.mem_wr     <= '0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    size_q  <= bus.req_size;
                    off_q   <= off_in;
                    uns_q   <= bus.req_unsigned;
                    cnt     <= 2'd1;
                    raddr_q <= addr_al;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (mis) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                    end else
`endif
                    if (bus.req_we) begin
                        state            <= STORE;
                        bus.mem_wr       <= wr_lanes;
                        bus.mem_waddress <= addr_al;
                        bus.mem_datain   <= wdata_lanes;
                    end else begin
                        state <= LOAD_WAIT;
                    end
                end
                STORE: begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= '0;
                end
                LOAD_WAIT: if (cnt == 2'(RD_LAT)) begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= load_ext;
                end else begin
                    cnt <= cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem32_ctrl.sv
// tb_lsu_mem32_ctrl: directed load/store sequences against a byte-lane memory model with assertion checks
module tb_lsu_mem32_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [31:0] mem [0:63];
    logic [31:0] rd;
    logic [31:0] wa;
    logic [31:0] di;
    logic [3:0]  ws;
    logic        er;
    int lat, wcnt, acc, rcnt;

    lsu_mem32_ctrl_if #(.ADDR_W(32)) bus ();
    lsu_mem32_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut (.Clk(clk), .Reset(rst), .bus(bus));

    always #5 clk = ~clk;

    // four byte banks with a one-cycle registered read port
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.mem_wr[i]) mem[bus.mem_waddress[7:2]][8*i +: 8] <= bus.mem_datain[8*i +: 8];
        bus.mem_dataout <= mem[bus.mem_raddress[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wcnt = 0; ws = '0; wa = '0; di = '0; rd = 'x; er = 1'bx;
        lat = 1;
        while (lat < 20) begin
            if (bus.mem_wr != 4'b0) begin wcnt++; ws = bus.mem_wr; wa = bus.mem_waddress; di = bus.mem_datain; end
            if (bus.resp_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] exp);
        txn(1'b0, sz, u, a, 32'h0);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_err"}, {31'b0, er}, 0);
        chk({tag, "_nowr"}, wcnt, 0);
    endtask

    task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic [3:0] xwr, input logic [31:0] xdi);
        txn(1'b1, sz, 1'b0, a, d);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_wrcnt"}, wcnt, 1);
        chk({tag, "_wr"}, {28'b0, ws}, {28'b0, xwr});
        chk({tag, "_waddr"}, wa, {a[31:2], 2'b00});
        chk({tag, "_datain"}, di, xdi);
        chk({tag, "_rdata"}, rd, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.req_ready}, 0);
        chk("rst_rvalid", {31'b0, bus.resp_valid}, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_err", {31'b0, bus.resp_err}, 0);
        chk("rst_wr", {28'b0, bus.mem_wr}, 0);
        chk("rst_raddr", bus.mem_raddress, 0);
        chk("rst_waddr", bus.mem_waddress, 0);
        chk("rst_datain", bus.mem_datain, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'b0, bus.req_ready}, 1);

        store("sw100", 2'b10, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("pulse_end", {31'b0, bus.resp_valid}, 0);
        chk("b2b_ready", {31'b0, bus.req_ready}, 1);
        load("lw100", 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        load("lb103", 2'b00, 1'b0, 32'h103, 32'hFFFFFFDE);
        load("lbu103", 2'b00, 1'b1, 32'h103, 32'h000000DE);
        load("lh102", 2'b01, 1'b0, 32'h102, 32'hFFFFDEAD);
        load("lhu100", 2'b01, 1'b1, 32'h100, 32'h0000BEEF);
        store("sb101", 2'b00, 32'h101, 32'h00000055, 4'b0010, 32'h55555555);
        load("lw100b", 2'b10, 1'b0, 32'h100, 32'hDEAD55EF);
        store("sh102", 2'b01, 32'h102, 32'h0000CAFE, 4'b1100, 32'hCAFECAFE);
        load("lw100c", 2'b10, 1'b0, 32'h100, 32'hCAFE55EF);
        load("lb100", 2'b00, 1'b0, 32'h100, 32'hFFFFFFEF);
        load("lb101", 2'b00, 1'b0, 32'h101, 32'h00000055);
        load("lh100", 2'b01, 1'b0, 32'h100, 32'h000055EF);
        load("lres100", 2'b11, 1'b0, 32'h100, 32'hCAFE55EF);

`ifdef LSU_MISALIGN_TRAP_EN
        txn(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        chk("lw102_lat", lat, 1);
        chk("lw102_err", {31'b0, er}, 1);
        chk("lw102_data", rd, 0);
        chk("lw102_nowr", wcnt, 0);
        txn(1'b1, 2'b10, 1'b0, 32'h103, 32'h12345678);
        chk("sw103_lat", lat, 1);
        chk("sw103_err", {31'b0, er}, 1);
        chk("sw103_nowr", wcnt, 0);
        txn(1'b1, 2'b01, 1'b0, 32'h101, 32'h00001234);
        chk("sh101_err", {31'b0, er}, 1);
        chk("sh101_nowr", wcnt, 0);
        load("lw100d", 2'b10, 1'b0, 32'h100, 32'hCAFE55EF);
`else
        load("lw102", 2'b10, 1'b0, 32'h102, 32'hCAFE55EF);
        load("lh101", 2'b01, 1'b1, 32'h101, 32'h000055EF);
        store("sw103", 2'b10, 32'h103, 32'h12345678, 4'b1111, 32'h12345678);
        store("sh101", 2'b01, 32'h101, 32'h0000ABCD, 4'b0011, 32'hABCDABCD);
        load("lw100d", 2'b10, 1'b0, 32'h100, 32'h1234ABCD);
`endif

        // reset while the load is waiting on memory must swallow the response
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h100;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        rcnt = 0;
        repeat (4) begin @(posedge clk); #1; if (bus.resp_valid) rcnt++; end
        chk("rstmid_resp", rcnt, 0);
        chk("rstmid_ready", {31'b0, bus.req_ready}, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rstmid_idle", {31'b0, bus.req_ready}, 1);

        // request held high across a whole store is taken once
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h104; bus.req_wdata = 32'h11223344;
        acc = 0; wcnt = 0; rcnt = 0;
        repeat (3) begin
            if (bus.req_ready) acc++;
            @(posedge clk); #1;
            if (bus.mem_wr != 4'b0) wcnt++;
            if (bus.resp_valid) rcnt++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.mem_wr != 4'b0) wcnt++;
            if (bus.resp_valid) rcnt++;
        end
        chk("hold_accepts", acc, 1);
        chk("hold_writes", wcnt, 1);
        chk("hold_resps", rcnt, 1);
        load("lw104", 2'b10, 1'b0, 32'h104, 32'h11223344);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
